dmem_responder: RTL and testbench

Data-memory responder for the 16-bit pipeline: the memory-side end of the load/store interface driven by the memory stage. It accepts one read or write request at a time over a valid/ready handshake, models WAIT_CYCLES of access latency, and returns a one-cycle response pulse with read data. Its busy output drives the pipeline stall logic.

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request port, WAIT_CYCLES of latency, one-cycle response pulse.
// Optional address range check is compiled in with `define DMEM_RANGE_CHECK_EN.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]        state_r;
    logic [1:0]        next_s;
    logic [3:0]        wcnt_r;
    logic              write_r;
    logic [ADDR_W-1:0] addr_r;
    logic [15:0]       wdata_r;
    logic [15:0]       rdata_r;
    logic              ready_r;
    logic              valid_r;
    logic              busy_r;
    logic              accept_s;
    logic              err_s;
    logic [15:0]       mem_r [0:DEPTH-1];

`ifdef DMEM_RANGE_CHECK_EN
    logic err_r;
    logic rsp_err_r;

    function automatic logic addr_out_of_range(input logic [15:0] addr);
        return (addr >> ADDR_W) != 16'd0;
    endfunction

    // Latch the range error with the request and present it only during RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_r     <= 1'b0;
            rsp_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                err_r <= addr_out_of_range(req_addr);
            end else begin
                err_r <= err_r;
            end
            rsp_err_r <= (state_r == S_ACCESS) ? err_r : 1'b0;
        end
    end

    assign err_s   = err_r;
    assign rsp_err = rsp_err_r;
`else
    // Upper address bits simply alias in this build
    logic unused_addr_s;
    assign unused_addr_s = ^(req_addr >> ADDR_W);
    assign err_s         = 1'b0;
    assign rsp_err       = 1'b0;
`endif

    assign accept_s = req_valid && ready_r;

    // Next-state decode; RESP accepts back-to-back exactly like IDLE
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE, S_RESP: begin
                if (accept_s) begin
                    next_s = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt_r == 4'd1) begin
                    next_s = S_ACCESS;
                end else begin
                    next_s = S_WAIT;
                end
            end
            S_ACCESS: next_s = S_RESP;
            default:  next_s = S_IDLE;
        endcase
    end

    // FSM, request capture, wait counter and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            wcnt_r  <= 4'd0;
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= 16'h0000;
            rdata_r <= 16'h0000;
        end else begin
            state_r <= next_s;
            ready_r <= (next_s == S_IDLE) || (next_s == S_RESP);
            valid_r <= (next_s == S_RESP);
            busy_r  <= (next_s != S_IDLE);
            if (accept_s) begin
                write_r <= req_write;
                addr_r  <= req_addr[ADDR_W-1:0];
                wdata_r <= req_wdata;
                wcnt_r  <= WAIT_LOAD;
            end else if (state_r == S_WAIT) begin
                wcnt_r <= wcnt_r - 4'd1;
            end else begin
                wcnt_r <= wcnt_r;
            end
            if (state_r == S_ACCESS) begin
                rdata_r <= err_s ? 16'h0000 : (write_r ? wdata_r : mem_r[addr_r]);
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Array write at the ACCESS edge; contents deliberately not reset
    always_ff @(posedge clk) begin
        if ((state_r == S_ACCESS) && write_r && !err_s) begin
            mem_r[addr_r] <= wdata_r;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = valid_r;
    assign rsp_rdata = rdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: instance a uses WAIT_CYCLES=2, instance b WAIT_CYCLES=0.
// Address-range expectations follow `define DMEM_RANGE_CHECK_EN.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        a_valid, a_write, a_ready, a_rvalid, a_err, a_busy;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        b_valid, b_write, b_ready, b_rvalid, b_err, b_busy;
    logic [15:0] b_addr, b_wdata, b_rdata;

    int checks   = 0;
    int failures = 0;
    int acc_a    = 0;
    int rsp_a    = 0;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_err(a_err), .busy(a_busy)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepts and response pulses of instance a
    always @(posedge clk) begin
        if (a_valid && a_ready) acc_a <= acc_a + 1;
        if (a_rvalid) rsp_a <= rsp_a + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One request on instance a; lat counts negedges from the accept edge to the RESP cycle
    task automatic req_a(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         output int lat, output logic [15:0] rd, output logic er);
        int n;
        @(negedge clk);
        a_valid = 1'b1; a_write = wr; a_addr = addr; a_wdata = wdata;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1 a_valid = 1'b0;
        lat = -1; rd = 16'hxxxx; er = 1'bx;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (a_rvalid) begin
                lat = i; rd = a_rdata; er = a_err;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        er;
        int          acc0, rsp0, gaps, pulses;
        logic [4:0]  pat;

        reset = 1'b0;
        a_valid = 1'b0; a_write = 1'b0; a_addr = 16'h0000; a_wdata = 16'h0000;
        b_valid = 1'b0; b_write = 1'b0; b_addr = 16'h0000; b_wdata = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("rst_ready",  32'(a_ready),  32'd1);
        check_val("rst_rvalid", 32'(a_rvalid), 32'd0);
        check_val("rst_rdata",  32'(a_rdata),  32'h0000);
        check_val("rst_err",    32'(a_err),    32'd0);
        check_val("rst_busy",   32'(a_busy),   32'd0);
        check_val("rst_b_ready", 32'(b_ready), 32'd1);
        reset = 1'b1;

        // Basic store/load
        req_a(1'b1, 16'h0010, 16'hBEEF, lat, rd, er);
        check_val("st_lat",   32'(lat), 32'd4);
        check_val("st_echo",  32'(rd),  32'hBEEF);
        check_val("st_err",   32'(er),  32'd0);
        req_a(1'b0, 16'h0010, 16'h0000, lat, rd, er);
        check_val("ld_lat",   32'(lat), 32'd4);
        check_val("ld_data",  32'(rd),  32'hBEEF);

        // Reset in the first WAIT cycle aborts a store
        req_a(1'b1, 16'h0020, 16'h0000, lat, rd, er);
        @(negedge clk);
        a_valid = 1'b1; a_write = 1'b1; a_addr = 16'h0020; a_wdata = 16'hAAAA;
        @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rstw_busy",  32'(a_busy),  32'd0);
        check_val("rstw_ready", 32'(a_ready), 32'd1);
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b1;
            if (a_rvalid) pulses++;
        end
        check_val("rstw_no_rsp", 32'(pulses), 32'd0);
        req_a(1'b0, 16'h0020, 16'h0000, lat, rd, er);
        check_val("rstw_lat",  32'(lat), 32'd4);
        check_val("rstw_data", 32'(rd),  32'h0000);

        // Upper address bits: alias or range error
        req_a(1'b1, 16'h0003, 16'h0033, lat, rd, er);
        req_a(1'b1, 16'h0103, 16'h5A5A, lat, rd, er);
        check_val("hi_lat", 32'(lat), 32'd4);
`ifdef DMEM_RANGE_CHECK_EN
        check_val("hi_err",   32'(er), 32'd1);
        check_val("hi_rdata", 32'(rd), 32'h0000);
        req_a(1'b0, 16'h0003, 16'h0000, lat, rd, er);
        check_val("hi_keep",  32'(rd), 32'h0033);
        check_val("hi_ld_err", 32'(er), 32'd0);
`else
        check_val("hi_err",   32'(er), 32'd0);
        check_val("hi_echo",  32'(rd), 32'h5A5A);
        req_a(1'b0, 16'h0003, 16'h0000, lat, rd, er);
        check_val("hi_alias", 32'(rd), 32'h5A5A);
        check_val("hi_ld_err", 32'(er), 32'd0);
`endif

        // Stall signalling: three loads with req_valid held high
        @(negedge clk);
        acc0 = acc_a; rsp0 = rsp_a; gaps = 0;
        a_valid = 1'b1; a_write = 1'b0; a_addr = 16'h0010;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if ((acc_a - acc0) >= 1 && (rsp_a - rsp0) < 3 && !a_busy) gaps++;
            if ((acc_a - acc0) >= 3) a_valid = 1'b0;
            if ((rsp_a - rsp0) >= 3) break;
        end
        check_val("stall_gaps", 32'(gaps), 32'd0);
        check_val("stall_acc",  32'(acc_a - acc0), 32'd3);
        check_val("stall_rsp",  32'(rsp_a - rsp0), 32'd3);
        check_val("stall_idle", 32'(a_busy), 32'd0);

        // Back-to-back on the zero-wait instance
        @(negedge clk);
        b_valid = 1'b1; b_write = 1'b1; b_addr = 16'h0005; b_wdata = 16'h1234;
        pat[4] = b_ready;
        @(posedge clk);
        #1 b_write = 1'b0; b_wdata = 16'h0000;
        @(negedge clk);
        pat[3] = b_ready;
        @(negedge clk);
        pat[2] = b_ready;
        check_val("b2b_st_valid", 32'(b_rvalid), 32'd1);
        check_val("b2b_st_echo",  32'(b_rdata),  32'h1234);
        @(posedge clk);
        #1 b_valid = 1'b0;
        @(negedge clk);
        pat[1] = b_ready;
        check_val("b2b_gap_valid", 32'(b_rvalid), 32'd0);
        @(negedge clk);
        pat[0] = b_ready;
        check_val("b2b_ld_valid", 32'(b_rvalid), 32'd1);
        check_val("b2b_ld_data",  32'(b_rdata),  32'h1234);
        check_val("b2b_ready_pat", 32'(pat), 32'b10101);
        @(negedge clk);
        check_val("b2b_end_valid", 32'(b_rvalid), 32'd0);
        check_val("b2b_end_busy",  32'(b_busy),   32'd0);
        check_val("b2b_hold_data", 32'(b_rdata),  32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
